// File: rtl/i2s_tdm_fir_mux.sv
// i2s_tdm_fir_mux
//   Shares one packet-mode FIR interpolator across CHANNELS audio channels.
//   Sink side: a parallel frame from the I2S receiver is serialised into an
//   sop/eop-framed beat stream, channel 0 first. A one-deep pending register
//   absorbs a frame that arrives while the previous one is still going out.
//   Source side: FIR output beats are collected into slots and presented as a
//   parallel frame when a correctly sized frame closes with eop.
//
// Ports
//   AMCLK_i                  audio master clock (only clock)
//   ARST                     synchronous active-high reset
//   in_data_i / in_valid_i   parallel input frame, channel k at [k*IN_W +: IN_W]
//   sink_data_o              beat towards the FIR
//   sink_valid_o/_sop_o/_eop_o  FIR sink framing
//   source_data_i            beat from the FIR (signed, passed through as-is)
//   source_valid_i/_sop_i/_eop_i  FIR source framing
//   out_data_o / out_valid_o reassembled frame and its one-cycle strobe
//   overrun_o                sticky: an input frame was dropped
//   frame_err_o              sticky: a malformed source frame was discarded
module i2s_tdm_fir_mux #(
    parameter int CHANNELS = 2,
    parameter int IN_W     = 16,
    parameter int OUT_W    = 24,
    parameter int SINK_GAP = 1
) (
    input  logic                      AMCLK_i,
    input  logic                      ARST,
    input  logic [CHANNELS*IN_W-1:0]  in_data_i,
    input  logic                      in_valid_i,
    output logic [IN_W-1:0]           sink_data_o,
    output logic                      sink_valid_o,
    output logic                      sink_sop_o,
    output logic                      sink_eop_o,
    input  logic [OUT_W-1:0]          source_data_i,
    input  logic                      source_valid_i,
    input  logic                      source_sop_i,
    input  logic                      source_eop_i,
    output logic [CHANNELS*OUT_W-1:0] out_data_o,
    output logic                      out_valid_o,
    output logic                      overrun_o,
    output logic                      frame_err_o
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WI_W  = $clog2(CHANNELS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic [WI_W-1:0]  LAST_WI  = WI_W'(CHANNELS - 1);
    localparam logic [WI_W-1:0]  NUM_WI   = WI_W'(CHANNELS);
    localparam logic [3:0]       GAP_LAST = 4'((SINK_GAP > 0) ? SINK_GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } sink_state_t;

    // ---------------- sink side: frame -> beats ----------------
    sink_state_t               r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [3:0]                r_gap_cnt;
    logic [CHANNELS*IN_W-1:0]  r_send_sr;   // shifts down one channel per beat
    logic [CHANNELS*IN_W-1:0]  r_pend_buf;
    logic                      r_pend_full;
    logic [IN_W-1:0]           r_sink_data;
    logic                      r_sink_valid;
    logic                      r_sink_sop;
    logic                      r_sink_eop;
    logic                      r_overrun;
    logic                      w_direct_take;

    // A strobe is taken straight into the send buffer only when the FSM is idle
    // and has no pending frame of its own to send; otherwise it goes to pending.
    assign w_direct_take = (r_state == S_IDLE) && !r_pend_full;

    always_ff @(posedge AMCLK_i) begin
        if (ARST) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_gap_cnt    <= '0;
            r_pend_full  <= 1'b0;
            r_sink_data  <= '0;
            r_sink_valid <= 1'b0;
            r_sink_sop   <= 1'b0;
            r_sink_eop   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_sink_valid <= 1'b0;
            r_sink_sop   <= 1'b0;
            r_sink_eop   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_pend_full) begin
                        r_send_sr   <= r_pend_buf;
                        r_pend_full <= 1'b0;
                        r_idx       <= '0;
                        r_state     <= S_SEND;
                    end else if (in_valid_i) begin
                        r_send_sr <= in_data_i;
                        r_idx     <= '0;
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_sink_valid <= 1'b1;
                    r_sink_data  <= r_send_sr[IN_W-1:0];
                    r_send_sr    <= r_send_sr >> IN_W;
                    r_sink_sop   <= (r_idx == '0);
                    r_sink_eop   <= (r_idx == LAST_IDX);
                    if (r_idx == LAST_IDX) begin
                        r_gap_cnt <= '0;
                        r_state   <= (SINK_GAP == 0) ? S_IDLE : S_GAP;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A pending frame being consumed still counts as occupied this cycle.
            if (in_valid_i && !w_direct_take) begin
                if (r_pend_full) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pend_buf  <= in_data_i;
                    r_pend_full <= 1'b1;
                end
            end
        end
    end

    assign sink_data_o  = r_sink_data;
    assign sink_valid_o = r_sink_valid;
    assign sink_sop_o   = r_sink_sop;
    assign sink_eop_o   = r_sink_eop;
    assign overrun_o    = r_overrun;

    // ---------------- source side: beats -> frame ----------------
    logic [CHANNELS*OUT_W-1:0] r_slots;
    logic [WI_W-1:0]           r_wi;
    logic                      r_in_frame;
    logic [CHANNELS*OUT_W-1:0] r_out_data;
    logic                      r_out_valid;
    logic                      r_frame_err;

    logic signed [OUT_W-1:0]   w_src_beat;
    logic [WI_W-1:0]           w_land;
    logic                      w_accept;
    logic                      w_complete;
    logic                      w_err;
    logic [CHANNELS*OUT_W-1:0] w_frame;

    assign w_src_beat = source_data_i;
    assign w_land     = source_sop_i ? '0 : r_wi;
    assign w_accept   = source_valid_i &&
                        (source_sop_i || (r_in_frame && (r_wi < NUM_WI)));
    assign w_complete = w_accept && source_eop_i && (w_land == LAST_WI);
    assign w_err      = source_valid_i &&
                        ((source_sop_i && r_in_frame) || !w_accept ||
                         (source_eop_i && !w_complete));

    // Frame as it will look once the current beat is written, so the eop beat
    // can be published in the same cycle it arrives.
    always_comb begin
        w_frame = r_slots;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_land == WI_W'(k)) begin
                w_frame[k*OUT_W +: OUT_W] = w_src_beat;
            end
        end
    end

    always_ff @(posedge AMCLK_i) begin
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_accept && (w_land == WI_W'(k))) begin
                r_slots[k*OUT_W +: OUT_W] <= w_src_beat;
            end
        end
    end

    always_ff @(posedge AMCLK_i) begin
        if (ARST) begin
            r_wi        <= '0;
            r_in_frame  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (source_valid_i) begin
                if (w_accept) begin
                    r_wi       <= w_land + WI_W'(1);
                    r_in_frame <= !source_eop_i;
                end else begin
                    r_in_frame <= 1'b0;
                end
            end
            if (w_complete) begin
                r_out_data  <= w_frame;
                r_out_valid <= 1'b1;
            end
            if (w_err) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign out_data_o  = r_out_data;
    assign out_valid_o = r_out_valid;
    assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_i2s_tdm_fir_mux.sv
module tb_i2s_tdm_fir_mux;

    localparam int C  = 3;
    localparam int IW = 16;
    localparam int OW = 24;
    localparam int SG = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (C channels)
    logic              rst;
    logic [C*IW-1:0]   in_data;
    logic              in_valid;
    logic [IW-1:0]     sink_data;
    logic              sink_valid, sink_sop, sink_eop;
    logic [OW-1:0]     src_data;
    logic              src_valid, src_sop, src_eop;
    logic [C*OW-1:0]   out_data;
    logic              out_valid, overrun, frame_err;

    // single-channel instance
    logic [IW-1:0]     in_data_1;
    logic              in_valid_1;
    logic [IW-1:0]     sink_data_1;
    logic              sink_valid_1, sink_sop_1, sink_eop_1;
    logic [OW-1:0]     src_data_1;
    logic              src_valid_1, src_sop_1, src_eop_1;
    logic [OW-1:0]     out_data_1;
    logic              out_valid_1, overrun_1, frame_err_1;

    i2s_tdm_fir_mux #(.CHANNELS(C), .IN_W(IW), .OUT_W(OW), .SINK_GAP(SG)) u_dut (
        .AMCLK_i(clk), .ARST(rst),
        .in_data_i(in_data), .in_valid_i(in_valid),
        .sink_data_o(sink_data), .sink_valid_o(sink_valid),
        .sink_sop_o(sink_sop), .sink_eop_o(sink_eop),
        .source_data_i(src_data), .source_valid_i(src_valid),
        .source_sop_i(src_sop), .source_eop_i(src_eop),
        .out_data_o(out_data), .out_valid_o(out_valid),
        .overrun_o(overrun), .frame_err_o(frame_err)
    );

    i2s_tdm_fir_mux #(.CHANNELS(1), .IN_W(IW), .OUT_W(OW), .SINK_GAP(0)) u_dut1 (
        .AMCLK_i(clk), .ARST(rst),
        .in_data_i(in_data_1), .in_valid_i(in_valid_1),
        .sink_data_o(sink_data_1), .sink_valid_o(sink_valid_1),
        .sink_sop_o(sink_sop_1), .sink_eop_o(sink_eop_1),
        .source_data_i(src_data_1), .source_valid_i(src_valid_1),
        .source_sop_i(src_sop_1), .source_eop_i(src_eop_1),
        .out_data_o(out_data_1), .out_valid_o(out_valid_1),
        .overrun_o(overrun_1), .frame_err_o(frame_err_1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Sink: a schedule of expected beats keyed by clock-edge number.
    int                edge_n    = 0;
    int                idle_edge = 0;     // first edge at which the sink is free
    logic [C*IW-1:0]   pend_q[$];
    logic [IW+1:0]     exp_beat[int];     // {sop, eop, data}
    logic              m_overrun = 1'b0;
    // Source: beats of the current frame collected in a queue.
    logic [OW-1:0]     src_q[$];
    bit                m_in_frame = 1'b0;
    logic              m_err  = 1'b0;
    logic              m_oval = 1'b0;
    logic [C*OW-1:0]   m_out  = '0;

    task automatic schedule(input logic [C*IW-1:0] f, input int n);
        for (int k = 0; k < C; k++)
            exp_beat[n + 1 + k] = {(k == 0), (k == C - 1), f[k*IW +: IW]};
        idle_edge = n + C + SG + 1;
    endtask

    task automatic model_edge();
        bit acc;
        edge_n++;
        if (rst) begin
            exp_beat.delete();
            pend_q.delete();
            idle_edge  = edge_n + 1;
            m_overrun  = 1'b0;
            src_q.delete();
            m_in_frame = 0;
            m_err      = 1'b0;
            m_oval     = 1'b0;
            m_out      = '0;
            return;
        end
        // sink
        if (edge_n >= idle_edge) begin
            if (pend_q.size() != 0) begin
                schedule(pend_q.pop_front(), edge_n);
                if (in_valid) m_overrun = 1'b1;
            end else if (in_valid) begin
                schedule(in_data, edge_n);
            end
        end else if (in_valid) begin
            if (pend_q.size() == 0) pend_q.push_back(in_data);
            else m_overrun = 1'b1;
        end
        // source
        m_oval = 1'b0;
        if (src_valid) begin
            acc = 0;
            if (src_sop) begin
                if (m_in_frame) m_err = 1'b1;
                src_q.delete();
                src_q.push_back(src_data);
                m_in_frame = 1;
                acc = 1;
            end else if (m_in_frame && src_q.size() < C) begin
                src_q.push_back(src_data);
                acc = 1;
            end else begin
                m_err = 1'b1;
                m_in_frame = 0;
                src_q.delete();
            end
            if (acc && src_eop) begin
                if (src_q.size() == C) begin
                    for (int k = 0; k < C; k++) m_out[k*OW +: OW] = src_q[k];
                    m_oval = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_in_frame = 0;
                src_q.delete();
            end
        end
    endtask

    task automatic compare();
        logic [IW+1:0] b;
        chk("sink_valid", sink_valid, exp_beat.exists(edge_n));
        if (exp_beat.exists(edge_n)) begin
            b = exp_beat[edge_n];
            chk("sink_data", sink_data, b[IW-1:0]);
            chk("sink_sop", sink_sop, b[IW+1]);
            chk("sink_eop", sink_eop, b[IW]);
        end
        chk("overrun", overrun, m_overrun);
        chk("out_valid", out_valid, m_oval);
        chk("out_data", out_data, m_out);
        chk("frame_err", frame_err, m_err);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic src_beat(input logic [OW-1:0] d, input logic s, input logic e);
        src_valid = 1'b1; src_data = d; src_sop = s; src_eop = e;
        step();
        src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; src_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [C*OW-1:0] held;
    int p;

    initial begin
        rst = 1'b1;
        in_data = '0; in_valid = 1'b0;
        src_data = '0; src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0;
        in_data_1 = '0; in_valid_1 = 1'b0;
        src_data_1 = '0; src_valid_1 = 1'b0; src_sop_1 = 1'b0; src_eop_1 = 1'b0;
        step();
        step();
        // reset state
        chk("rst_sink_data", sink_data, '0);
        chk("rst_out_data", out_data, '0);
        chk("rst1_sink_valid", sink_valid_1, 1'b0);
        chk("rst1_out_data", out_data_1, '0);
        rst = 1'b0;
        idle(2);

        // single frame: ch0 then ch1 then ch2, then the gap
        in_data = {16'h5A5A, 16'hABCD, 16'h1234};
        in_valid = 1'b1; step(); in_valid = 1'b0;
        step();
        chk("f1_b0", {sink_valid, sink_sop, sink_eop, sink_data}, {3'b110, 16'h1234});
        step();
        chk("f1_b1", {sink_valid, sink_sop, sink_eop, sink_data}, {3'b100, 16'hABCD});
        step();
        chk("f1_b2", {sink_valid, sink_sop, sink_eop, sink_data}, {3'b101, 16'h5A5A});
        step();
        chk("f1_gap", sink_valid, 1'b0);
        idle(3);

        // three strobes one cycle apart: third is dropped
        for (int i = 0; i < 3; i++) begin
            in_data = {16'(i * 3 + 3), 16'(i * 3 + 2), 16'(i * 3 + 1)};
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("ovr_flag", overrun, 1'b1);
        idle(2 * (C + SG + 1) + 3);
        chk("ovr_sticky", overrun, 1'b1);
        do_reset();
        chk("ovr_cleared", overrun, 1'b0);
        idle(2);

        // source frame sop 1, 2, eop 3
        src_beat(24'h000001, 1'b1, 1'b0);
        src_beat(24'h000002, 1'b0, 1'b0);
        src_beat(24'h000003, 1'b0, 1'b1);
        chk("src_ok_valid", out_valid, 1'b1);
        chk("src_ok_data", out_data, 72'h000003_000002_000001);
        step();
        chk("src_ok_pulse", out_valid, 1'b0);

        // malformed: eop on the second beat
        src_beat(24'h000010, 1'b1, 1'b0);
        src_beat(24'h000020, 1'b0, 1'b1);
        chk("bad_err", frame_err, 1'b1);
        chk("bad_novalid", out_valid, 1'b0);
        chk("bad_hold", out_data, 72'h000003_000002_000001);
        src_beat(24'h000011, 1'b1, 1'b0);
        src_beat(24'h000022, 1'b0, 1'b0);
        src_beat(24'h000033, 1'b0, 1'b1);
        chk("after_bad_data", out_data, 72'h000033_000022_000011);
        chk("after_bad_valid", out_valid, 1'b1);
        idle(2);

        // reset in the middle of SEND
        in_data = {16'h3333, 16'h2222, 16'h1111};
        in_valid = 1'b1; step(); in_valid = 1'b0;
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_outs", {sink_valid, sink_sop, sink_eop, out_valid, overrun, frame_err}, 6'b0);
        chk("midrst_data", {sink_data, out_data}, '0);
        idle(4);
        in_data = {16'h6666, 16'h5555, 16'h4444};
        in_valid = 1'b1; step(); in_valid = 1'b0;
        step();
        chk("restart_sop", {sink_valid, sink_sop, sink_data}, {2'b11, 16'h4444});
        idle(C + SG + 2);

        // single-channel instance: sop and eop on one beat
        in_data_1 = 16'h7FFF; in_valid_1 = 1'b1; step(); in_valid_1 = 1'b0;
        step();
        chk("c1_beat", {sink_valid_1, sink_sop_1, sink_eop_1, sink_data_1}, {3'b111, 16'h7FFF});
        step();
        chk("c1_after", sink_valid_1, 1'b0);
        src_valid_1 = 1'b1; src_sop_1 = 1'b1; src_eop_1 = 1'b1; src_data_1 = 24'hFFFFFF;
        step();
        src_valid_1 = 1'b0; src_sop_1 = 1'b0; src_eop_1 = 1'b0;
        chk("c1_out", {out_valid_1, out_data_1}, {1'b1, 24'hFFFFFF});
        chk("c1_err", {frame_err_1, overrun_1}, 2'b00);
        step();
        chk("c1_pulse", {out_valid_1, out_data_1}, {1'b0, 24'hFFFFFF});

        // randomized traffic on both sides, with occasional resets
        p = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = (cyc % 250 == 249) || ($urandom_range(0, 399) == 0);
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = {$urandom, $urandom};
            src_valid = ($urandom_range(0, 2) != 0);
            src_data  = OW'($urandom);
            if (src_valid) begin
                if ($urandom_range(0, 15) == 0) begin
                    src_sop = 1'($urandom);
                    src_eop = 1'($urandom);
                end else begin
                    src_sop = (p == 0);
                    src_eop = (p == C - 1);
                end
                p = src_eop ? 0 : (p + 1) % C;
            end else begin
                src_sop = 1'($urandom);
                src_eop = 1'($urandom);
            end
            step();
        end
        rst = 1'b0;
        idle(C + SG + 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tdm_fir_mux.md
# i2s_tdm_fir_mux

Parametrised N-channel time-division multiplexer/demultiplexer that shares one packet-mode FIR interpolator across all audio channels of an I2S upsampler path. On the sink side it serialises one parallel multi-channel frame from the I2S receiver into an sop/eop-framed beat stream for the FIR. On the source side it reassembles the FIR output beats into a parallel frame for the I2S transmitter. It generalises the fixed two-channel muxed-FIR glue in several ways: parameterised channel count and widths, a one-deep frame backlog, configurable inter-frame gap, and sticky error reporting.

## Interface
- CHANNELS, 2: channels per frame, 1..8.
- IN_W, 16: input sample width per channel (FIR sink width).
- OUT_W, 24: output sample width per channel (FIR source width).
- SINK_GAP, 1: idle cycles forced after each sink frame's eop beat, 0..15.
- AMCLK_i  in  1  audio master clock; the only clock.
- ARST  in  1  synchronous, active-high reset.
- in_data_i  in  CHANNELS*IN_W  parallel input frame; channel k occupies bits [k*IN_W +: IN_W].
- in_valid_i  in  1  one-cycle strobe; the frame is valid this cycle.
- sink_data_o  out  IN_W  beat to the FIR.
- sink_valid_o / sink_sop_o / sink_eop_o  out  1 each  FIR sink framing.
- source_data_i  in  OUT_W  beat from the FIR (signed, passed through unchanged).
- source_valid_i / source_sop_i / source_eop_i  in  1 each  FIR source framing.
- out_data_o  out  CHANNELS*OUT_W  reassembled frame, same packing as the input.
- out_valid_o  out  1  one-cycle strobe; a new out_data_o is valid.
- overrun_o  out  1  sticky; an input frame was dropped.
- frame_err_o  out  1  sticky; a malformed source frame was discarded.

## Operation
- Sink FSM states:
  - IDLE: if the pending register is full, load it into the send buffer, clear pending, and go to SEND. Otherwise, if in_valid_i is high, capture in_data_i into the send buffer and go to SEND. Set idx=0 on either transition.
  - SEND: drive channel idx with sink_valid_o=1, sink_sop_o=(idx==0) and sink_eop_o=(idx==CHANNELS-1), then increment idx. After the eop beat, go to GAP, or go directly to IDLE when SINK_GAP=0.
  - GAP: hold sink_valid_o, sink_sop_o and sink_eop_o at 0 for SINK_GAP cycles, then go to IDLE.
- Channel order on the wire is ascending: channel 0 carries sop. When CHANNELS=1, sop and eop are asserted on the same beat.
- in_valid_i arriving in SEND or GAP, or in IDLE while pending is being consumed:
  - Stored into pending if pending is empty.
  - If pending is full, the new frame is dropped and overrun_o is set. Pending keeps the older frame.
- Source side: the write index wi and an in_frame flag.
  - Beat with source_sop_i: write slot 0, set wi=1 and in_frame=1. If in_frame was already 1 (sop arrived mid-frame), set frame_err_o; the new frame proceeds.
  - Beat without sop: if in_frame=1 and wi<CHANNELS, write slot wi and increment wi. Otherwise, set frame_err_o, clear in_frame and discard the beat.
  - Beat with source_eop_i: if the frame is complete (the beat lands in slot CHANNELS-1), copy all slots to out_data_o and pulse out_valid_o. Otherwise set frame_err_o and produce no out_valid_o. Clear in_frame in both cases.
- out_data_o holds its value between updates; a discarded frame never alters it.
- Widths: data is not rescaled or sign-modified on either side.

## Timing
- Reset (ARST high at a clock edge) has priority over all other inputs. It forces:
  - sink FSM to IDLE, pending empty, in_frame=0.
  - sink_valid_o, sink_sop_o, sink_eop_o, out_valid_o, overrun_o, frame_err_o to 0.
  - sink_data_o and out_data_o to all zeros.
- Reset mid-frame abandons all partial sink and source frames; no beat or strobe follows it.
- in_valid_i at edge t with the FSM in IDLE: beat for channel k is registered at t+1+k, eop at t+CHANNELS.
- The FSM is back in IDLE at t+1+CHANNELS+SINK_GAP. A pending frame's sop appears one cycle after that.
- Sustained throughput: one frame per CHANNELS+SINK_GAP+1 cycles.
- Source eop beat at edge s: out_data_o updated and out_valid_o high at s+1, low at s+2 unless another eop arrives.
- Sticky flags assert one cycle after the offending event and clear only on reset.
- Source side runs independently of sink side; simultaneous activity on both sides is required to work with no interaction.

## Test plan
- CHANNELS=2, SINK_GAP=1: in_valid with ch0=0x1234, ch1=0xABCD -> beats 0x1234 (sop), then 0xABCD (eop) on consecutive cycles, then 1 idle cycle.
- CHANNELS=4: three in_valid strobes 1 cycle apart -> frames 1 and 2 are sent back-to-back in order, frame 3 is dropped, overrun_o=1 from the cycle after strobe 3.
- CHANNELS=1: single input 0x7FFF -> one beat with sop=eop=1. Source beat 0xFFFFFF with sop+eop -> out_data_o=0xFFFFFF, out_valid_o pulse next cycle.
- CHANNELS=3, source beats sop 0x000001, 0x000002, eop 0x000003 -> out_data_o={0x000003,0x000002,0x000001}, one out_valid_o pulse.
- Malformed source: eop on the 2nd beat of a 3-channel frame -> frame_err_o=1, no out_valid_o, out_data_o unchanged. The next well-formed frame is delivered normally.
- ARST high mid-SEND on CHANNELS=4 after 2 beats -> no further sink beats, all outputs 0. The next in_valid restarts at channel 0 with sop.
